// File: rtl/digit_mac_stage.sv
// Digit-serial multiply-accumulate feeding the radix reduction stage:
// a_out = a_in + x_digit * y, processed CHUNK bits of y/a_in per cycle.
module digit_mac_stage #(
  parameter int SIZE  = 3072,
  parameter int RADIX = 78,
  parameter int CHUNK = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SIZE-1:0]       a_in,
  input  logic [SIZE-1:0]       y,
  input  logic [RADIX-1:0]      x_digit,
  output logic [SIZE+RADIX:0]   a_out,
  output logic                  busy,
  output logic                  en_out
);

  localparam int N  = SIZE / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = CHUNK + RADIX + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [RADIX:0]   carry;
  logic [RADIX-1:0] x_r;
  logic [SIZE-1:0]  y_r;
  logic [SIZE-1:0]  a_r;

  logic             accept;
  logic             last;
  int               base;
  logic [CHUNK-1:0] y_slice;
  logic [CHUNK-1:0] a_slice;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    p;

  assign accept = (state == IDLE) && start;
  assign last   = (k == KW'(N - 1));

  // One CHUNKxRADIX multiplier and one adder chain, reused for every slice.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    base    = int'(k) * CHUNK;
    y_slice = y_r[base +: CHUNK];
    a_slice = a_r[base +: CHUNK];
    prod    = {{(CHUNK + 1){1'b0}}, x_r} * {{(RADIX + 1){1'b0}}, y_slice};
    p       = prod + {{(RADIX + 1){1'b0}}, a_slice} + {{CHUNK{1'b0}}, carry};
  end

  // NOTE: operand registers are pure data captured on accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_r <= x_digit;
      y_r <= y;
      a_r <= a_in;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_out <= '0;
      carry <= '0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            carry <= '0;
            k     <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          a_out[base +: CHUNK] <= p[CHUNK-1:0];
          carry                <= p[PW-1:CHUNK];
          if (last) begin
            // The final carry becomes the top RADIX+1 bits of the result.
            a_out[SIZE+RADIX:SIZE] <= p[PW-1:CHUNK];
            state                  <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign en_out = (state == DONE);

endmodule

// File: tb/tb_digit_mac_stage.sv
// Randomized bench for digit_mac_stage against a wide-integer reference model.
module tb_digit_mac_stage;

  localparam int SIZE  = 3072;
  localparam int RADIX = 78;
  localparam int CHUNK = 128;
  localparam int N     = SIZE / CHUNK;
  localparam int W     = SIZE + RADIX + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [SIZE-1:0]  a_in;
  logic [SIZE-1:0]  y;
  logic [RADIX-1:0] x_digit;
  logic [W-1:0]     a_out;
  logic             busy;
  logic             en_out;

  int n_checks = 0;
  int n_errors = 0;

  digit_mac_stage #(.SIZE(SIZE), .RADIX(RADIX), .CHUNK(CHUNK)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .y       (y),
    .x_digit (x_digit),
    .a_out   (a_out),
    .busy    (busy),
    .en_out  (en_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    int idx;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      idx = -1;
      for (int i = W - 1; i >= 0; i--) begin
        if (got[i] !== exp[i]) begin
          idx = i;
          break;
        end
      end
      $display("FAIL %s: got low128=%h expected low128=%h (highest differing bit %0d)",
               tag, got[127:0], exp[127:0], idx);
    end
  endtask

  function automatic logic [SIZE-1:0] rand_wide();
    logic [SIZE-1:0] v;
    for (int i = 0; i < SIZE / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [RADIX-1:0] rand_x();
    logic [SIZE-1:0] t;
    t = rand_wide();
    return t[RADIX-1:0];
  endfunction

  // Reference: the plain integer sum a + x*y in a result-wide variable.
  function automatic logic [W-1:0] model(input logic [SIZE-1:0] av, input logic [SIZE-1:0] yv,
                                         input logic [RADIX-1:0] xv);
    logic [W-1:0] aw, yw, xw;
    aw = av;
    yw = yv;
    xw = xv;
    return aw + yw * xw;
  endfunction

  // Entered just after a falling edge with the DUT idle; leaves one cycle after en_out.
  task automatic run_op(input logic [SIZE-1:0] av, input logic [SIZE-1:0] yv,
                        input logic [RADIX-1:0] xv, input string tag);
    logic [W-1:0] exp_v;
    int cnt;
    exp_v = model(av, yv, xv);
    check({tag, "_idle_busy"}, W'(busy), W'(0));
    start   = 1'b1;
    a_in    = av;
    y       = yv;
    x_digit = xv;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    a_in    = rand_wide();
    y       = rand_wide();
    x_digit = rand_x();
    check({tag, "_calc_busy"}, W'(busy), W'(1));
    cnt = 0;
    while (!en_out && cnt < N + 8) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, W'(cnt), W'(N));
    check({tag, "_a_out"}, a_out, exp_v);
    check({tag, "_done_busy"}, W'(busy), W'(1));
    @(negedge clk);
    check({tag, "_en_width"}, W'(en_out), W'(0));
    check({tag, "_end_busy"}, W'(busy), W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SIZE-1:0]  ones;
    logic [SIZE-1:0]  av, yv;
    logic [RADIX-1:0] xv;
    logic [W-1:0]     exp_v;
    int pulses, first_at, second_at, low_between, cnt, sel;

    rst_n   = 1'b0;
    start   = 1'b0;
    a_in    = '0;
    y       = '0;
    x_digit = '0;
    ones    = '1;
    repeat (3) @(negedge clk);
    check("reset_a_out", a_out, '0);
    check("reset_busy", W'(busy), W'(0));
    check("reset_en", W'(en_out), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Zero digit leaves a_in unchanged.
    run_op(SIZE'(5), rand_wide(), '0, "x_zero");

    // Carry ripples through every slice into bit SIZE.
    run_op(SIZE'(1), ones, RADIX'(1), "ripple");
    check("ripple_top", W'(a_out[SIZE]), W'(1));

    // Largest operands: top result bit stays clear.
    xv = '1;
    run_op(ones, ones, xv, "all_ones");
    check("all_ones_msb", W'(a_out[SIZE+RADIX]), W'(0));

    // start held high: restarts only from IDLE, never queued.
    av = rand_wide();
    yv = rand_wide();
    xv = rand_x();
    exp_v = model(av, yv, xv);
    start   = 1'b1;
    a_in    = av;
    y       = yv;
    x_digit = xv;
    pulses = 0;
    first_at = -1;
    second_at = -1;
    low_between = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (en_out) begin
        pulses++;
        if (pulses == 1) first_at = i;
        if (pulses == 2) second_at = i;
        check("held_a_out", a_out, exp_v);
      end else if (pulses == 1 && !busy) begin
        low_between++;
      end
    end
    start = 1'b0;
    check("held_pulses", W'(pulses), W'(2));
    check("held_first", W'(first_at), W'(N));
    check("held_spacing", W'(second_at - first_at), W'(N + 2));
    check("held_busy_gap", W'(low_between), W'(1));
    cnt = 0;
    while (busy && cnt < 3 * N) begin
      @(negedge clk);
      cnt++;
    end
    check("held_drain", W'(busy), W'(0));

    // Asynchronous reset in the 10th CALC cycle aborts the operation.
    start   = 1'b1;
    a_in    = rand_wide();
    y       = rand_wide();
    x_digit = rand_x();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_a_out", a_out, '0);
    check("abort_busy", W'(busy), W'(0));
    check("abort_en", W'(en_out), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (en_out) pulses++;
    end
    check("abort_no_en", W'(pulses), W'(0));
    run_op(rand_wide(), rand_wide(), rand_x(), "after_abort");

    // Back-to-back random operations with occasional extreme operands.
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 9);
      av = (sel == 0) ? ones : rand_wide();
      yv = (sel == 1) ? ones : rand_wide();
      xv = (sel == 2) ? '1 : ((sel == 3) ? '0 : rand_x());
      run_op(av, yv, xv, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
